// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared definitions for the instruction fetch unit: default field widths,
//   the opcode constants the fetch unit cares about, the fetch FSM state
//   encoding and the command set of the PC sub-unit.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

   // Default geometry: a word is {opcode, operand/address}.
   localparam int ADDR_W_DEF    = 12;
   localparam int OP_W_DEF      = 5;
   localparam int INSTR_W_DEF   = 17;
   localparam int MEM_DEPTH_DEF = 2048;

   // Opcodes the fetch unit has to recognise. Both conditional jumps hand
   // control to the core, which later reports the outcome on br_*.
   localparam logic [OP_W_DEF-1:0] OP_NOP  = 5'd0;
   localparam logic [OP_W_DEF-1:0] OP_JPNZ = 5'd20;
   localparam logic [OP_W_DEF-1:0] OP_JMPZ = 5'd21;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_BRWAIT
   } fetch_state_t;

   // What the PC unit should do this cycle.
   typedef enum logic [1:0] {
      PC_KEEP,
      PC_ZERO,
      PC_INC,
      PC_BRANCH
   } pc_cmd_t;

   function automatic logic is_branch_op(input logic [OP_W_DEF-1:0] op);
      return (op == OP_JPNZ) || (op == OP_JMPZ);
   endfunction

endpackage

// File: rtl/instr_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//   Program counter register with its next-PC mux (keep / zero / increment /
//   branch) and the address range check that drives the sticky fault flag.
//   A move that would leave 0..MEM_DEPTH-1 leaves the PC untouched and sets
//   fault instead; PC_ZERO (used on start) clears fault.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     cmd          PC update command from the fetch FSM
//     br_target    jump destination used by PC_BRANCH
//     pc           current program counter
//     at_end       pc is the last valid address (increment would overflow)
//     tgt_oob      br_target lies outside the memory
//     fault        sticky range-error flag
// ---------------------------------------------------------------------------
module pc_unit
   import instr_fetch_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  pc_cmd_t           cmd,
   input  logic [ADDR_W-1:0] br_target,
   output logic [ADDR_W-1:0] pc,
   output logic              at_end,
   output logic              tgt_oob,
   output logic              fault
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic              fault_reg, fault_next;

   // Range checks are pure functions of the current PC / target so the FSM
   // can pick its next state without a combinational path through cmd.
   assign at_end  = (pc_reg == LAST_ADDR);
   assign tgt_oob = (br_target > LAST_ADDR);

   always_comb begin
      pc_next    = pc_reg;
      fault_next = fault_reg;
      case (cmd)
         PC_ZERO: begin
            pc_next    = '0;
            fault_next = 1'b0;
         end
         PC_INC: begin
            if (at_end) begin
               fault_next = 1'b1;
            end else begin
               pc_next = pc_reg + ADDR_W'(1);
            end
         end
         PC_BRANCH: begin
            if (tgt_oob) begin
               fault_next = 1'b1;
            end else begin
               pc_next = br_target;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg    <= '0;
         fault_reg <= 1'b0;
      end else begin
         pc_reg    <= pc_next;
         fault_reg <= fault_next;
      end
   end

   assign pc    = pc_reg;
   assign fault = fault_reg;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetch unit between a 1-cycle registered instruction memory and the core.
//   Issues one read at a time (REQ), captures the returned word (WAIT),
//   presents it on a valid/ready handshake (HOLD) and, for conditional
//   jumps, waits for the core's branch outcome (BRWAIT).
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     start                    pulse: begin fetching at PC 0 (IDLE only)
//     halt                     stop and return to IDLE (non-IDLE states)
//     mem_read_en, mem_addr    instruction memory read port
//     mem_instr                memory data, valid the cycle after the read
//     instr_valid/instr_ready  presentation handshake to the core
//     instr_op, instr_operand  opcode and operand fields of the word
//     instr_pc                 address the presented word came from
//     br_valid/taken/target    branch outcome from the core
//     busy                     not IDLE
//     done                     1-cycle pulse after a halt-induced return
//     fault                    sticky: PC tried to leave the memory range
// ---------------------------------------------------------------------------
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int OP_W      = OP_W_DEF,
   parameter int INSTR_W   = INSTR_W_DEF,   // must equal OP_W + ADDR_W
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               halt,
   output logic               mem_read_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [INSTR_W-1:0] mem_instr,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [OP_W-1:0]    instr_op,
   output logic [ADDR_W-1:0]  instr_operand,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               br_valid,
   input  logic               br_taken,
   input  logic [ADDR_W-1:0]  br_target,
   output logic               busy,
   output logic               done,
   output logic               fault
);

   fetch_state_t state_reg, state_next;
   pc_cmd_t      pc_cmd;
   logic         capture;
   logic         done_reg, done_next;

   logic [OP_W-1:0]   op_reg;
   logic [ADDR_W-1:0] operand_reg;
   logic [ADDR_W-1:0] ipc_reg;

   logic [ADDR_W-1:0] pc;
   logic              at_end;
   logic              tgt_oob;

   pc_unit #(
      .ADDR_W    (ADDR_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_pc (
      .clk       (clk),
      .rst       (rst),
      .cmd       (pc_cmd),
      .br_target (br_target),
      .pc        (pc),
      .at_end    (at_end),
      .tgt_oob   (tgt_oob),
      .fault     (fault)
   );

   // Next-state / control. halt outranks everything outside IDLE, including
   // an acceptance in the same cycle, so the PC is never advanced then.
   always_comb begin
      state_next = state_reg;
      pc_cmd     = PC_KEEP;
      capture    = 1'b0;
      done_next  = 1'b0;

      if (state_reg == ST_IDLE) begin
         if (start) begin
            pc_cmd     = PC_ZERO;
            state_next = ST_REQ;
         end
      end else if (halt) begin
         state_next = ST_IDLE;
         done_next  = 1'b1;
      end else begin
         case (state_reg)
            ST_REQ: begin
               state_next = ST_WAIT;
            end
            ST_WAIT: begin
               capture    = 1'b1;
               state_next = ST_HOLD;
            end
            ST_HOLD: begin
               if (instr_ready) begin
                  if (is_branch_op(op_reg)) begin
                     state_next = ST_BRWAIT;
                  end else begin
                     pc_cmd     = PC_INC;
                     state_next = at_end ? ST_IDLE : ST_REQ;
                  end
               end
            end
            ST_BRWAIT: begin
               if (br_valid) begin
                  if (br_taken) begin
                     pc_cmd     = PC_BRANCH;
                     state_next = tgt_oob ? ST_IDLE : ST_REQ;
                  end else begin
                     pc_cmd     = PC_INC;
                     state_next = at_end ? ST_IDLE : ST_REQ;
                  end
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         done_reg    <= 1'b0;
         op_reg      <= '0;
         operand_reg <= '0;
         ipc_reg     <= '0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
         // The word is only taken in WAIT, so a read still in flight when
         // halt or reset hits never reaches the output registers.
         if (capture) begin
            op_reg      <= mem_instr[INSTR_W-1:ADDR_W];
            operand_reg <= mem_instr[ADDR_W-1:0];
            ipc_reg     <= pc;
         end
      end
   end

   // The PC only changes on the edge into REQ (or not at all on a fault),
   // so driving the address straight from it holds it between reads.
   assign mem_read_en   = (state_reg == ST_REQ);
   assign mem_addr      = pc;
   assign instr_valid   = (state_reg == ST_HOLD);
   assign instr_op      = op_reg;
   assign instr_operand = operand_reg;
   assign instr_pc      = ipc_reg;
   assign busy          = (state_reg != ST_IDLE);
   assign done          = done_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Directed scenarios plus a randomized program walk for instr_fetch,
//   against a behavioural memory and a plain program-counter model.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

   localparam int ADDR_W  = 12;
   localparam int OP_W    = 5;
   localparam int INSTR_W = 17;
   localparam int DEPTH   = 2048;

   localparam logic [4:0] JPNZ = 5'd20;
   localparam logic [4:0] JMPZ = 5'd21;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               halt;
   logic               mem_read_en;
   logic [ADDR_W-1:0]  mem_addr;
   logic [INSTR_W-1:0] mem_instr;
   logic               instr_valid;
   logic               instr_ready;
   logic [OP_W-1:0]    instr_op;
   logic [ADDR_W-1:0]  instr_operand;
   logic [ADDR_W-1:0]  instr_pc;
   logic               br_valid;
   logic               br_taken;
   logic [ADDR_W-1:0]  br_target;
   logic               busy;
   logic               done;
   logic               fault;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .halt          (halt),
      .mem_read_en   (mem_read_en),
      .mem_addr      (mem_addr),
      .mem_instr     (mem_instr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_op      (instr_op),
      .instr_operand (instr_operand),
      .instr_pc      (instr_pc),
      .br_valid      (br_valid),
      .br_taken      (br_taken),
      .br_target     (br_target),
      .busy          (busy),
      .done          (done),
      .fault         (fault)
   );

   // Instruction memory: 1-cycle registered read.
   logic [INSTR_W-1:0] mem [0:DEPTH-1];
   int rd_count = 0;
   int rd_oob   = 0;

   always @(posedge clk) begin
      if (mem_read_en) begin
         rd_count <= rd_count + 1;
         if (mem_addr >= ADDR_W'(DEPTH))
            rd_oob <= rd_oob + 1;
         else
            mem_instr <= mem[mem_addr];
      end
   end

   int tests  = 0;
   int failed = 0;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_read(output int waited);
      waited = 0;
      while (mem_read_en !== 1'b1 && waited < 20) begin
         tick;
         waited++;
      end
      chk("read_seen", {31'd0, mem_read_en}, 32'd1);
   endtask

   task automatic start_fetch;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   // Expect one instruction fetched from pc, held for 'stall' cycles with
   // ready low, then accepted. Returns cycles spent waiting for the read.
   task automatic expect_instr(input logic [ADDR_W-1:0] pc, input int stall, output int waited);
      logic [INSTR_W-1:0] word;
      word = mem[pc];
      wait_read(waited);
      chk("req_addr", 32'(mem_addr), 32'(pc));
      tick;
      chk("wait_valid_low", {31'd0, instr_valid}, 32'd0);
      tick;
      chk("valid", {31'd0, instr_valid}, 32'd1);
      chk("instr_pc", 32'(instr_pc), 32'(pc));
      chk("instr_op", 32'(instr_op), 32'(word[16:12]));
      chk("instr_operand", 32'(instr_operand), 32'(word[11:0]));
      for (int s = 0; s < stall; s++) begin
         tick;
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
         chk("stall_stable", 32'({instr_op, instr_operand, instr_pc}), 32'({word, pc}));
         chk("stall_no_read", {31'd0, mem_read_en}, 32'd0);
      end
      instr_ready = 1'b1;
      tick;
      instr_ready = 1'b0;
      chk("accept_valid_low", {31'd0, instr_valid}, 32'd0);
   endtask

   task automatic resolve(input int wcyc, input logic taken, input logic [ADDR_W-1:0] tgt);
      for (int i = 0; i < wcyc; i++) begin
         chk("brwait_no_read", {31'd0, mem_read_en}, 32'd0);
         tick;
      end
      br_valid  = 1'b1;
      br_taken  = taken;
      br_target = tgt;
      tick;
      br_valid  = 1'b0;
      br_taken  = 1'b0;
   endtask

   task automatic do_halt;
      halt = 1'b1;
      tick;
      halt = 1'b0;
      chk("halt_done", {31'd0, done}, 32'd1);
      chk("halt_busy", {31'd0, busy}, 32'd0);
      chk("halt_fault", {31'd0, fault}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      tick;
      chk("halt_done_pulse", {31'd0, done}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int rc;
      logic [ADDR_W-1:0] model_pc;
      logic [INSTR_W-1:0] word;
      logic tk;
      logic [ADDR_W-1:0] tg;

      rst = 1'b1; start = 1'b0; halt = 1'b0; instr_ready = 1'b0;
      br_valid = 1'b0; br_taken = 1'b0; br_target = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      repeat (3) tick;

      // Reset state
      chk("rst_outputs", 32'({instr_valid, busy, done, fault, mem_read_en}), 32'd0);
      chk("rst_fields", 32'({instr_op, instr_operand}), 32'd0);
      chk("rst_addr_pc", 32'({mem_addr, instr_pc}), 32'd0);
      rst = 1'b0;
      tick;

      // Linear fetch, back-to-back
      mem[0] = {5'd1, 12'h000};
      mem[1] = {5'd2, 12'h000};
      mem[2] = {5'd3, 12'h000};
      mem[3] = {5'd4, 12'h055};
      rc = rd_count;
      start_fetch;
      expect_instr(12'd0, 0, w);
      chk("lin_first_wait", w, 0);
      expect_instr(12'd1, 0, w);
      chk("lin_throughput1", w, 0);
      expect_instr(12'd2, 0, w);
      chk("lin_throughput2", w, 0);
      chk("lin_read_count", rd_count - rc, 3);
      do_halt;

      // Stall in HOLD
      start_fetch;
      expect_instr(12'd0, 5, w);
      expect_instr(12'd1, 0, w);
      do_halt;

      // Branches
      mem[0]  = {JMPZ, 12'd29};
      mem[29] = {JPNZ, 12'd0};
      mem[30] = {5'd4, 12'h123};
      start_fetch;
      expect_instr(12'd0, 0, w);
      resolve(0, 1'b1, 12'd29);
      expect_instr(12'd29, 0, w);
      resolve(3, 1'b1, 12'd0);
      expect_instr(12'd0, 1, w);
      resolve(1, 1'b1, 12'd29);
      expect_instr(12'd29, 0, w);
      resolve(3, 1'b0, 12'd0);
      wait_read(w);
      chk("br_not_taken_addr", 32'(mem_addr), 32'd30);
      do_halt;

      // Halt during WAIT
      start_fetch;
      tick;
      halt = 1'b1;
      tick;
      halt = 1'b0;
      chk("hw_done", {31'd0, done}, 32'd1);
      chk("hw_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("hw_valid_low", {31'd0, instr_valid}, 32'd0);
      end
      chk("hw_done_pulse", {31'd0, done}, 32'd0);

      // Halt in IDLE: no effect
      halt = 1'b1;
      tick;
      halt = 1'b0;
      chk("idle_halt", 32'({done, busy}), 32'd0);

      // start and halt together in IDLE: start wins
      start = 1'b1; halt = 1'b1;
      tick;
      start = 1'b0; halt = 1'b0;
      chk("start_halt_busy", {31'd0, busy}, 32'd1);
      chk("start_halt_done", {31'd0, done}, 32'd0);
      do_halt;

      // End of memory
      mem[0]    = {JMPZ, 12'd0};
      mem[2047] = {5'd7, 12'hABC};
      start_fetch;
      expect_instr(12'd0, 0, w);
      resolve(0, 1'b1, 12'd2047);
      rc = rd_count;
      expect_instr(12'd2047, 0, w);
      chk("eom_fault", {31'd0, fault}, 32'd1);
      chk("eom_idle", 32'({busy, done, mem_read_en}), 32'd0);
      tick;
      tick;
      chk("eom_no_extra_read", rd_count - rc, 1);
      chk("eom_no_oob_read", rd_oob, 0);
      start_fetch;
      chk("start_clears_fault", {31'd0, fault}, 32'd0);
      expect_instr(12'd0, 0, w);
      resolve(0, 1'b1, 12'd2048);
      chk("br_oob_fault", {31'd0, fault}, 32'd1);
      chk("br_oob_idle", 32'({busy, done, mem_read_en}), 32'd0);
      start_fetch;
      chk("start_clears_fault2", {31'd0, fault}, 32'd0);
      do_halt;

      // Reset mid-HOLD
      mem[0] = {5'd9, 12'h3C3};
      start_fetch;
      wait_read(w);
      tick;
      tick;
      chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("midrst_outputs", 32'({instr_valid, busy, done, fault, mem_read_en}), 32'd0);
      chk("midrst_fields", 32'({instr_op, instr_operand}), 32'd0);
      chk("midrst_addr_pc", 32'({mem_addr, instr_pc}), 32'd0);
      tick;
      tick;
      chk("midrst_stays_idle", 32'({instr_valid, busy, mem_read_en}), 32'd0);

      // Randomized program walk against the PC model
      for (int i = 0; i < 256; i++) begin
         mem[i] = INSTR_W'($urandom);
      end
      model_pc = '0;
      start_fetch;
      for (int n = 0; n < 40; n++) begin
         word = mem[model_pc];
         expect_instr(model_pc, int'($urandom_range(0, 2)), w);
         if (word[16:12] == JPNZ || word[16:12] == JMPZ) begin
            tk = 1'($urandom_range(0, 1));
            tg = ADDR_W'($urandom_range(0, 200));
            resolve(int'($urandom_range(0, 3)), tk, tg);
            model_pc = tk ? tg : model_pc + 12'd1;
         end else begin
            model_pc = model_pc + 12'd1;
         end
      end
      wait_read(w);
      chk("rand_final_addr", 32'(mem_addr), 32'(model_pc));
      do_halt;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
